pri_issue_ctrl: RTL and testbench

- Issue-side sequencer between dispatch and the pipeline controller; serializes privileged instructions (CSR, TLB, cache-op, syscall/break/ertn, idle).
- A privileged instruction at dispatch slot 0 is held until all older in-flight instructions retire, then issued alone. Dispatch stays blocked until that instruction retires or a flush occurs.
- Also tracks the in-flight instruction count and blocks dispatch when the in-flight window is full.

---
 rtl/pri_issue_ctrl_if.sv | 26 ++
 rtl/pri_issue_ctrl.sv | 131 +++++++++++++
 tb/tb_pri_issue_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pri_issue_ctrl_if.sv
// Dispatch-side bundle of the privileged-instruction issue controller.
// The master modport is the dispatch/commit side; the slave modport is the controller.
interface pri_issue_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             is_pri_instr_i;
  logic [1:0]       issue_cnt_i;
  logic [1:0]       retire_cnt_i;
  logic             pri_retire_i;
  logic             flush_i;
  logic             block_o;
  logic             single_issue_o;
  logic             pri_busy_o;
  logic [CNT_W-1:0] inflight_o;
  logic             inflight_full_o;

  modport master (
    output is_pri_instr_i, issue_cnt_i, retire_cnt_i, pri_retire_i, flush_i,
    input  block_o, single_issue_o, pri_busy_o, inflight_o, inflight_full_o
  );

  modport slave (
    input  is_pri_instr_i, issue_cnt_i, retire_cnt_i, pri_retire_i, flush_i,
    output block_o, single_issue_o, pri_busy_o, inflight_o, inflight_full_o
  );
endinterface

// File: rtl/pri_issue_ctrl.sv
// Serializes privileged instructions at dispatch: drain older work, issue alone,
// hold dispatch until retirement. Also tracks the in-flight window occupancy.
module pri_issue_ctrl #(
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = 4
) (
  input  logic           clk,
  input  logic           rst,
  pri_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_e;

  localparam logic [CNT_W:0] MAX_W = (CNT_W + 1)'(MAX_INFLIGHT);
  localparam logic [CNT_W:0] TWO_W = (CNT_W + 1)'(2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;

  logic [CNT_W:0]   sum_w;
  logic [CNT_W:0]   retire_w;
  logic [CNT_W:0]   diff_w;
  logic             underflow;
  logic [CNT_W-1:0] cnt_next;
  logic             full;
  logic             block_fsm;
  logic             single_fsm;

  // Occupancy arithmetic is done one bit wider so an over-retire is detectable.
  always_comb begin
    sum_w     = {1'b0, inflight_q} + {{(CNT_W - 1){1'b0}}, bus.issue_cnt_i};
    retire_w  = {{(CNT_W - 1){1'b0}}, bus.retire_cnt_i};
    underflow = retire_w > sum_w;
    diff_w    = sum_w - retire_w;
    cnt_next  = underflow ? '0 : diff_w[CNT_W-1:0];
    full      = ({1'b0, inflight_q} + TWO_W) > MAX_W;
  end

  always_comb begin
    inflight_d = cnt_next;
    if (bus.flush_i) begin
      inflight_d = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    block_fsm  = 1'b0;
    single_fsm = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.is_pri_instr_i) begin
          if (inflight_q == '0) begin
            // Empty pipeline: the privileged instruction may go out this very cycle.
            single_fsm = 1'b1;
            state_d    = (bus.issue_cnt_i != 2'd0) ? WAIT : ISSUE;
          end else begin
            block_fsm = 1'b1;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        block_fsm = 1'b1;
        if (cnt_next == '0) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        single_fsm = 1'b1;
        if (bus.issue_cnt_i != 2'd0) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        block_fsm = 1'b1;
        if (bus.pri_retire_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (bus.flush_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
    end
  end

  assign bus.block_o         = bus.flush_i | block_fsm | full;
  assign bus.single_issue_o  = ~bus.flush_i & single_fsm;
  assign bus.pri_busy_o      = (state_q != IDLE);
  assign bus.inflight_o      = inflight_q;
  assign bus.inflight_full_o = full;

`ifndef SYNTHESIS
  // The privileged instruction must be issued strictly alone.
  a_single_issue: assert property (@(posedge clk) disable iff (rst || bus.flush_i)
    ((state_q == ISSUE) || (state_q == IDLE && bus.is_pri_instr_i && inflight_q == '0))
      |-> (bus.issue_cnt_i < 2'd2))
    else $error("pri_issue_ctrl: dual issue alongside a privileged instruction");

  a_no_underflow: assert property (@(posedge clk) disable iff (rst || bus.flush_i)
    !underflow)
    else $error("pri_issue_ctrl: retire count exceeds in-flight count");

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || bus.flush_i)
    (underflow || diff_w <= MAX_W))
    else $error("pri_issue_ctrl: in-flight window exceeded");

  a_pri_retire_in_wait: assert property (@(posedge clk) disable iff (rst)
    bus.pri_retire_i |-> (state_q == WAIT))
    else $warning("pri_issue_ctrl: pri_retire_i outside WAIT ignored");
`endif

endmodule

// File: tb/tb_pri_issue_ctrl.sv
// Directed bench for pri_issue_ctrl; every expected value is worked out by hand
// from the intended state/counter sequence.
module tb_pri_issue_ctrl;

  localparam int MAX_INFLIGHT = 8;
  localparam int CNT_W        = 4;

  logic clk;
  logic rst;
  int   checkCount;
  int   failCount;

  pri_issue_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pri_issue_ctrl #(
    .MAX_INFLIGHT(MAX_INFLIGHT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic isPri, input logic [1:0] issue, input logic [1:0] retire,
                               input logic priRet, input logic flush);
    bus.is_pri_instr_i = isPri;
    bus.issue_cnt_i    = issue;
    bus.retire_cnt_i   = retire;
    bus.pri_retire_i   = priRet;
    bus.flush_i        = flush;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst        = 1'b1;
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

    // Reset with random input activity.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                    2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      stepClock();
    end
    rst = 1'b0;
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("rst_block",    32'(bus.block_o),         32'd0);
    checkOutput("rst_single",   32'(bus.single_issue_o),  32'd0);
    checkOutput("rst_busy",     32'(bus.pri_busy_o),      32'd0);
    checkOutput("rst_inflight", 32'(bus.inflight_o),      32'd0);
    checkOutput("rst_full",     32'(bus.inflight_full_o), 32'd0);

    // Throughput and window-full behaviour.
    applyStimulus(1'b0, 2'd2, 2'd0, 1'b0, 1'b0);
    stepClock();
    checkOutput("thru_inflight2", 32'(bus.inflight_o), 32'd2);
    stepClock();
    checkOutput("thru_inflight4", 32'(bus.inflight_o), 32'd4);
    stepClock();
    checkOutput("thru_inflight6", 32'(bus.inflight_o), 32'd6);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("thru6_full",  32'(bus.inflight_full_o), 32'd0);
    checkOutput("thru6_block", 32'(bus.block_o),         32'd0);
    applyStimulus(1'b0, 2'd1, 2'd0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("full7_inflight", 32'(bus.inflight_o),      32'd7);
    checkOutput("full7_full",     32'(bus.inflight_full_o), 32'd1);
    checkOutput("full7_block",    32'(bus.block_o),         32'd1);
    applyStimulus(1'b0, 2'd0, 2'd2, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("ret5_inflight", 32'(bus.inflight_o),      32'd5);
    checkOutput("ret5_full",     32'(bus.inflight_full_o), 32'd0);
    checkOutput("ret5_block",    32'(bus.block_o),         32'd0);
    applyStimulus(1'b0, 2'd0, 2'd2, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("ret3_inflight", 32'(bus.inflight_o), 32'd3);

    // Drain path: IDLE -> DRAIN -> ISSUE -> WAIT -> IDLE.
    applyStimulus(1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("idle_pri_block",  32'(bus.block_o),        32'd1);
    checkOutput("idle_pri_single", 32'(bus.single_issue_o), 32'd0);
    stepClock();
    checkOutput("drain_busy",  32'(bus.pri_busy_o), 32'd1);
    checkOutput("drain_block", 32'(bus.block_o),    32'd1);
    applyStimulus(1'b1, 2'd0, 2'd1, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("drain2_inflight", 32'(bus.inflight_o),     32'd2);
    checkOutput("drain2_block",    32'(bus.block_o),        32'd1);
    checkOutput("drain2_single",   32'(bus.single_issue_o), 32'd0);
    applyStimulus(1'b1, 2'd0, 2'd2, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("issue_inflight", 32'(bus.inflight_o),     32'd0);
    checkOutput("issue_single",   32'(bus.single_issue_o), 32'd1);
    checkOutput("issue_block",    32'(bus.block_o),        32'd0);
    checkOutput("issue_busy",     32'(bus.pri_busy_o),     32'd1);
    applyStimulus(1'b1, 2'd1, 2'd0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("wait_inflight", 32'(bus.inflight_o),     32'd1);
    checkOutput("wait_block",    32'(bus.block_o),        32'd1);
    checkOutput("wait_single",   32'(bus.single_issue_o), 32'd0);
    checkOutput("wait_busy",     32'(bus.pri_busy_o),     32'd1);
    applyStimulus(1'b0, 2'd0, 2'd1, 1'b1, 1'b0);
    checkOutput("wait_ret_block", 32'(bus.block_o), 32'd1);
    stepClock();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("resume_block",    32'(bus.block_o),    32'd0);
    checkOutput("resume_busy",     32'(bus.pri_busy_o), 32'd0);
    checkOutput("resume_inflight", 32'(bus.inflight_o), 32'd0);

    // Fast path: empty pipeline, privileged instruction issues at once.
    applyStimulus(1'b1, 2'd1, 2'd0, 1'b0, 1'b0);
    checkOutput("fast_single", 32'(bus.single_issue_o), 32'd1);
    checkOutput("fast_block",  32'(bus.block_o),        32'd0);
    stepClock();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("fast_wait_busy",     32'(bus.pri_busy_o), 32'd1);
    checkOutput("fast_wait_inflight", 32'(bus.inflight_o), 32'd1);
    checkOutput("fast_wait_block",    32'(bus.block_o),    32'd1);

    // Flush in WAIT with five in flight and an issue in the flush cycle.
    applyStimulus(1'b0, 2'd2, 2'd0, 1'b0, 1'b0);
    stepClock();
    stepClock();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("pre_flush_inflight", 32'(bus.inflight_o), 32'd5);
    checkOutput("pre_flush_busy",     32'(bus.pri_busy_o), 32'd1);
    applyStimulus(1'b0, 2'd1, 2'd0, 1'b0, 1'b1);
    checkOutput("flush_block",  32'(bus.block_o),        32'd1);
    checkOutput("flush_single", 32'(bus.single_issue_o), 32'd0);
    stepClock();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("post_flush_inflight", 32'(bus.inflight_o), 32'd0);
    checkOutput("post_flush_busy",     32'(bus.pri_busy_o), 32'd0);
    checkOutput("post_flush_block",    32'(bus.block_o),    32'd0);

    // Simultaneous issue and retire net out.
    applyStimulus(1'b0, 2'd2, 2'd0, 1'b0, 1'b0);
    stepClock();
    stepClock();
    applyStimulus(1'b0, 2'd2, 2'd2, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("net_inflight", 32'(bus.inflight_o), 32'd4);

    // Reset together with flush from a busy state.
    applyStimulus(1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    stepClock();
    checkOutput("pre_rst_busy", 32'(bus.pri_busy_o), 32'd1);
    rst = 1'b1;
    applyStimulus(1'b1, 2'd2, 2'd0, 1'b0, 1'b1);
    stepClock();
    rst = 1'b0;
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("rstflush_inflight", 32'(bus.inflight_o),     32'd0);
    checkOutput("rstflush_busy",     32'(bus.pri_busy_o),     32'd0);
    checkOutput("rstflush_block",    32'(bus.block_o),        32'd0);
    checkOutput("rstflush_single",   32'(bus.single_issue_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
